// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS core: tracks E/M/W destinations with their
// remaining Tnew and a mult/div busy count, and derives stall/bubble and D-stage forwarding.
module hazard_scoreboard #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] tnew_D,
   input  logic [1:0] tuse1_D,
   input  logic [1:0] tuse2_D,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [4:0] dest_D,
   input  logic       md_start_D,
   input  logic       md_is_div_D,
   input  logic       hilo_use_D,
   output logic       stall,
   output logic       bubble_E,
   output logic [1:0] fwd_rs_sel,
   output logic [1:0] fwd_rt_sel,
   output logic       md_busy
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

   logic [4:0]       destE_q, destE_d;
   logic [1:0]       tnewE_q, tnewE_d;
   logic [4:0]       destM_q, destM_d;
   logic [1:0]       tnewM_q, tnewM_d;
   logic [4:0]       destW_q, destW_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic stallRs, stallRt, stallMd;

   // A result still being produced in E or M is a hazard only if it arrives later than the operand is needed.
   assign stallRs = (rs_D != 5'd0) && (tuse1_D != 2'd3) &&
                    (((destE_q == rs_D) && (tnewE_q > tuse1_D)) ||
                     ((destM_q == rs_D) && (tnewM_q > tuse1_D)));
   assign stallRt = (rt_D != 5'd0) && (tuse2_D != 2'd3) &&
                    (((destE_q == rt_D) && (tnewE_q > tuse2_D)) ||
                     ((destM_q == rt_D) && (tnewM_q > tuse2_D)));

   assign md_busy  = (cnt_q != '0);
   assign stallMd  = hilo_use_D && md_busy;
   assign stall    = stallRs | stallRt | stallMd;
   assign bubble_E = stall;

   always_comb begin
      fwd_rs_sel = 2'd0;
      fwd_rt_sel = 2'd0;
      // Only the nearest matching stage may forward; if it is not ready yet the stall covers it.
      if (rs_D != 5'd0) begin
         if (destE_q == rs_D)      fwd_rs_sel = (tnewE_q == 2'd0) ? 2'd1 : 2'd0;
         else if (destM_q == rs_D) fwd_rs_sel = (tnewM_q == 2'd0) ? 2'd2 : 2'd0;
         else if (destW_q == rs_D) fwd_rs_sel = 2'd3;
      end
      if (rt_D != 5'd0) begin
         if (destE_q == rt_D)      fwd_rt_sel = (tnewE_q == 2'd0) ? 2'd1 : 2'd0;
         else if (destM_q == rt_D) fwd_rt_sel = (tnewM_q == 2'd0) ? 2'd2 : 2'd0;
         else if (destW_q == rt_D) fwd_rt_sel = 2'd3;
      end
   end

   always_comb begin
      destW_d = destM_q;
      destM_d = destE_q;
      tnewM_d = (tnewE_q == 2'd0) ? 2'd0 : tnewE_q - 2'd1;
      destE_d = 5'd0;
      tnewE_d = 2'd0;
      cnt_d   = cnt_q;
      if (!stall) begin
         destE_d = dest_D;
         tnewE_d = tnew_D;
      end
      if (!stall && md_start_D) begin
         cnt_d = md_is_div_D ? DIV_LD : MULT_LD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         destE_q <= 5'd0;
         tnewE_q <= 2'd0;
         destM_q <= 5'd0;
         tnewM_q <= 2'd0;
         destW_q <= 5'd0;
         cnt_q   <= '0;
      end else begin
         destE_q <= destE_d;
         tnewE_q <= tnewE_d;
         destM_q <= destM_d;
         tnewM_q <= tnewM_d;
         destW_q <= destW_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed instruction-sequence table, an async reset during a
// divide, then random traffic compared against an issue-history reference model.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] tnew_D, tuse1_D, tuse2_D;
   logic [4:0] rs_D, rt_D, dest_D;
   logic       md_start_D, md_is_div_D, hilo_use_D;
   logic       stall, bubble_E, md_busy;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk(clk), .rst_n(rst_n),
      .tnew_D(tnew_D), .tuse1_D(tuse1_D), .tuse2_D(tuse2_D),
      .rs_D(rs_D), .rt_D(rt_D), .dest_D(dest_D),
      .md_start_D(md_start_D), .md_is_div_D(md_is_div_D), .hilo_use_D(hilo_use_D),
      .stall(stall), .bubble_E(bubble_E),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
   );

   typedef struct {
      logic [1:0] tnew, tuse1, tuse2;
      logic [4:0] rs, rt, dest;
      logic       mdStart, mdDiv, hilo;
      logic       expStall;
      logic [1:0] expRs, expRt;
      logic       expBusy;
   } vec_t;

   typedef struct {
      int dest;
      int tnew;
   } rec_t;

   vec_t tbl[$];

   // Reference model: the last three instructions that entered E, newest first.
   rec_t hist[$];
   int   edgeCount, mdEdge, mdLen;

   function automatic vec_t mk(int tn, int u1, int u2, int rs, int rt, int dst,
                               int ms, int md, int hl, int es, int er, int et, int eb);
      vec_t v;
      v.tnew = 2'(tn);  v.tuse1 = 2'(u1);  v.tuse2 = 2'(u2);
      v.rs = 5'(rs);    v.rt = 5'(rt);     v.dest = 5'(dst);
      v.mdStart = 1'(ms); v.mdDiv = 1'(md); v.hilo = 1'(hl);
      v.expStall = 1'(es); v.expRs = 2'(er); v.expRt = 2'(et); v.expBusy = 1'(eb);
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      tnew_D = v.tnew;  tuse1_D = v.tuse1;  tuse2_D = v.tuse2;
      rs_D = v.rs;      rt_D = v.rt;        dest_D = v.dest;
      md_start_D = v.mdStart; md_is_div_D = v.mdDiv; hilo_use_D = v.hilo;
   endtask

   task automatic checkOutput(input string tag, input logic eStall, input logic [1:0] eRs,
                              input logic [1:0] eRt, input logic eBusy);
      checks++;
      if (stall !== eStall) begin
         errors++;
         $display("[TB] FAIL %s stall: got %0b expected %0b", tag, stall, eStall);
      end
      checks++;
      if (bubble_E !== eStall) begin
         errors++;
         $display("[TB] FAIL %s bubble_E: got %0b expected %0b", tag, bubble_E, eStall);
      end
      checks++;
      if (fwd_rs_sel !== eRs) begin
         errors++;
         $display("[TB] FAIL %s fwd_rs_sel: got %0d expected %0d", tag, fwd_rs_sel, eRs);
      end
      checks++;
      if (fwd_rt_sel !== eRt) begin
         errors++;
         $display("[TB] FAIL %s fwd_rt_sel: got %0d expected %0d", tag, fwd_rt_sel, eRt);
      end
      checks++;
      if (md_busy !== eBusy) begin
         errors++;
         $display("[TB] FAIL %s md_busy: got %0b expected %0b", tag, md_busy, eBusy);
      end
   endtask

   function automatic void modelReset();
      rec_t z;
      z.dest = 0;
      z.tnew = 0;
      hist = {};
      for (int k = 0; k < 3; k++) hist.push_back(z);
      edgeCount = 0;
      mdEdge = 0;
      mdLen = 0;
   endfunction

   function automatic int remaining(int age);
      return (hist[age].tnew > age) ? hist[age].tnew - age : 0;
   endfunction

   function automatic logic modelHazard(int addr, int tuse);
      if (addr == 0 || tuse == 3) return 1'b0;
      for (int age = 0; age < 2; age++)
         if (hist[age].dest == addr && remaining(age) > tuse) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [1:0] modelFwd(int addr);
      if (addr == 0) return 2'd0;
      for (int age = 0; age < 3; age++)
         if (hist[age].dest == addr)
            return (age == 2 || remaining(age) == 0) ? 2'(age + 1) : 2'd0;
      return 2'd0;
   endfunction

   function automatic logic modelBusy();
      return (mdLen - (edgeCount - mdEdge)) > 0;
   endfunction

   function automatic logic modelStall();
      return modelHazard(int'(rs_D), int'(tuse1_D)) || modelHazard(int'(rt_D), int'(tuse2_D)) ||
             (hilo_use_D && modelBusy());
   endfunction

   function automatic void modelEdge(logic s);
      rec_t r;
      edgeCount++;
      r.dest = s ? 0 : int'(dest_D);
      r.tnew = s ? 0 : int'(tnew_D);
      hist.push_front(r);
      void'(hist.pop_back());
      if (!s && md_start_D) begin
         mdEdge = edgeCount;
         mdLen  = md_is_div_D ? 10 : 5;
      end
   endfunction

   initial begin
      vec_t mflo;
      logic eS;

      rst_n = 1'b0;
      applyStimulus(mk(0, 3, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      rs_D = 5'd7;
      repeat (2) @(negedge clk);
      checkOutput("resetHeld", 1'b0, 2'd0, 2'd0, 1'b0);
      rst_n = 1'b1;

      // Directed instruction sequences, one record per D-stage cycle.
      tbl.push_back(mk(2, 1, 3, 29, 8, 8,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 8, 8, 9,   0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 8, 8, 9,   0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 3, 0, 8, 8,   0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 8, 0, 0,   0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 8, 0, 0,   0, 0, 0, 0, 2, 0, 0));
      tbl.push_back(mk(0, 3, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3, 3, 0, 0, 31,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 3, 31, 0, 0,  0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 3, 3, 31, 0, 0,  0, 0, 0, 0, 2, 0, 0));
      tbl.push_back(mk(0, 3, 3, 31, 0, 0,  0, 0, 0, 0, 3, 0, 0));
      tbl.push_back(mk(0, 1, 1, 4, 5, 0,   1, 0, 1, 0, 0, 0, 0));
      for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 3, 3, 0, 0, 10, 0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 3, 3, 0, 0, 10, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 4, 5, 0,   1, 1, 1, 0, 0, 0, 0));
      for (int k = 0; k < 10; k++) tbl.push_back(mk(1, 3, 3, 0, 0, 10, 0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 3, 3, 0, 0, 10, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(2, 1, 3, 29, 0, 0,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2, 1, 3, 29, 0, 12, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3, 3, 12, 12, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         applyStimulus(tbl[i]);
         #2;
         checkOutput($sformatf("vec%0d", i), tbl[i].expStall, tbl[i].expRs, tbl[i].expRt,
                     tbl[i].expBusy);
      end

      // Divide in flight, reset dropped asynchronously once the count reaches 6.
      mflo = mk(1, 3, 3, 0, 0, 10, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      applyStimulus(mk(0, 3, 3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      #2 checkOutput("divIssue", 1'b0, 2'd0, 2'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         applyStimulus(mflo);
         #2 checkOutput($sformatf("divWait%0d", k), 1'b1, 2'd0, 2'd0, 1'b1);
      end
      @(negedge clk);
      #2 checkOutput("divCnt6", 1'b1, 2'd0, 2'd0, 1'b1);
      #1 rst_n = 1'b0;
      #1 checkOutput("asyncReset", 1'b0, 2'd0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #2 checkOutput("mfloAfterReset", 1'b0, 2'd0, 2'd0, 1'b0);

      // Random traffic against the reference model, with one reset midway.
      @(negedge clk);
      rst_n = 1'b0;
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (i == 300) begin
            rst_n = 1'b0;
            modelReset();
            #2 checkOutput("rndReset", 1'b0, 2'd0, 2'd0, 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
         end
         tnew_D      = 2'($urandom_range(0, 3));
         tuse1_D     = 2'($urandom_range(0, 3));
         tuse2_D     = 2'($urandom_range(0, 3));
         rs_D        = 5'($urandom_range(0, 3));
         rt_D        = 5'($urandom_range(0, 3));
         dest_D      = 5'($urandom_range(0, 3));
         md_start_D  = ($urandom_range(0, 15) == 0);
         md_is_div_D = 1'($urandom_range(0, 1));
         hilo_use_D  = md_start_D || ($urandom_range(0, 3) == 0);
         #2;
         eS = modelStall();
         checkOutput($sformatf("rnd%0d", i), eS, modelFwd(int'(rs_D)), modelFwd(int'(rt_D)),
                     modelBusy());
         @(posedge clk);
         modelEdge(eS);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
